spi_txn_arb: RTL and testbench

- Two-requester arbiter and sequencer for the single SPI master that talks to the iNEMO inertial sensor.
- Requester 0 is the init/config sequencer; requester 1 is the heading reader in inert_intf.
- Each granted command becomes one SPI transaction: one wrt pulse, then wait for done.
- Returns read data to the winning requester, with round-robin fairness and a hang timeout.

---
 rtl/spi_txn_arb.sv | 137 +++++++++++++
 tb/tb_spi_txn_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_arb
// Summary  : Round-robin arbiter that turns requester commands into single
//            SPI master transactions, with a WAIT-state hang timeout.
// Revision : 1.0
// ============================================================================
module spi_txn_arb #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        timeout,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last, w_last_nxt;
  logic               r_owner, w_owner_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]        w_cmd_nxt, w_rd_nxt;
  logic               w_gnt0_nxt, w_gnt1_nxt, w_wrt_nxt;
  logic               w_done0_nxt, w_done1_nxt, w_tmo_nxt;
  logic               w_win;

  // Contention goes to whoever did not win last; a lone request always wins.
  assign w_win = (req0 && req1) ? ~r_last : req1;

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      cmd     <= 16'h0000;
      rd_data <= 16'h0000;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      wrt     <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      cmd     <= w_cmd_nxt;
      rd_data <= w_rd_nxt;
      gnt0    <= w_gnt0_nxt;
      gnt1    <= w_gnt1_nxt;
      wrt     <= w_wrt_nxt;
      done0   <= w_done0_nxt;
      done1   <= w_done1_nxt;
      timeout <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = cmd;
    w_rd_nxt    = rd_data;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_wrt_nxt   = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_tmo_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = ST_ISSUE;
          w_last_nxt  = w_win;
          w_owner_nxt = w_win;
          w_cmd_nxt   = w_win ? cmd1 : cmd0;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_wrt_nxt   = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // Completion is checked before the limit so a late spi_done still wins.
        if (spi_done) begin
          w_state_nxt = ST_IDLE;
          w_rd_nxt    = spi_rd_data;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = 1'b1;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_arb
// Summary  : Scoreboard bench for spi_txn_arb with a behavioural SPI slave.
// Revision : 1.0
// ============================================================================
module tb_spi_txn_arb;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] cmd0, cmd1;
  logic        gnt0, gnt1, done0, done1, busy, timeout, wrt;
  logic [15:0] rd_data, cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;

  spi_txn_arb #(.TIMEOUT_CYC(TMO)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .cmd0       (cmd0),
    .req1       (req1),
    .cmd1       (cmd1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .rd_data    (rd_data),
    .busy       (busy),
    .timeout    (timeout),
    .wrt        (wrt),
    .cmd        (cmd),
    .spi_done   (spi_done),
    .spi_rd_data(spi_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit own; logic [15:0] cmd; } gnt_t;
  typedef struct { int cyc; bit own; logic [15:0] rd; bit to; } done_t;
  typedef struct { bit to; int k; logic [15:0] data; } rsp_t;

  gnt_t  gq[$];
  done_t dq[$];
  rsp_t  rq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: arbitration history and last returned data.
  bit          m_last = 1'b1;
  logic [15:0] m_rd   = 16'h0000;
  int          idle_pulse_n = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every grant or completion the DUT shows is matched to the model.
  initial begin
    gnt_t  g;
    done_t d;
    forever begin
      @(negedge clk);
      if (gnt0 || gnt1 || wrt) begin
        if (gq.size() == 0) begin
          chk(1'b0, "unexpected_grant", {29'd0, wrt, gnt1, gnt0}, 32'd0);
        end else begin
          g = gq.pop_front();
          chk(cyc == g.cyc, "grant_cycle", cyc, g.cyc);
          chk({wrt, gnt1, gnt0} == {1'b1, g.own, ~g.own}, "grant_flags",
              {29'd0, wrt, gnt1, gnt0}, {29'd0, 1'b1, g.own, ~g.own});
          chk(cmd == g.cmd, "grant_cmd", cmd, g.cmd);
          chk(busy == 1'b1, "busy_in_issue", busy, 1);
        end
      end
      if (done0 || done1 || timeout) begin
        if (dq.size() == 0) begin
          chk(1'b0, "unexpected_done", {29'd0, timeout, done1, done0}, 32'd0);
        end else begin
          d = dq.pop_front();
          chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
          chk({timeout, done1, done0} == {d.to, d.own, ~d.own}, "done_flags",
              {29'd0, timeout, done1, done0}, {29'd0, d.to, d.own, ~d.own});
          chk(rd_data == d.rd, "done_rd_data", rd_data, d.rd);
          chk(busy == 1'b0, "busy_at_done", busy, 0);
        end
      end
    end
  end

  // SPI slave: answers each wrt after the scheduled number of WAIT cycles.
  initial begin
    rsp_t r;
    int   w;
    int   seen = 0;
    spi_done    = 1'b0;
    spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (idle_pulse_n != seen) begin
        seen        = idle_pulse_n;
        spi_done    = 1'b1;
        spi_rd_data = 16'hFFFF;
        @(negedge clk);
        spi_done    = 1'b0;
      end else if (wrt && rst_n) begin
        w = cyc;
        if (rq.size() == 0) begin
          chk(1'b0, "spi_no_response", 0, 1);
        end else begin
          r = rq.pop_front();
          if (!r.to) begin
            while (cyc < w + r.k) @(negedge clk);
            spi_done    = 1'b1;
            spi_rd_data = r.data;
            @(negedge clk);
            spi_done    = 1'b0;
            spi_rd_data = 16'($urandom);
          end
        end
      end
    end
  end

  // One transaction from an idle DUT; k is the WAIT cycle carrying spi_done.
  task automatic run_txn(input bit r0, input bit r1, input logic [15:0] c0, input logic [15:0] c1,
                         input int gap, input bit to, input int k, input logic [15:0] data);
    int g, d;
    bit own;
    repeat (gap) @(negedge clk);
    req0 = r0; req1 = r1; cmd0 = c0; cmd1 = c1;
    g   = cyc + 1;
    own = (r0 && r1) ? ~m_last : r1;
    m_last = own;
    d = to ? g + TMO + 1 : g + k + 1;
    if (!to) m_rd = data;
    gq.push_back('{cyc: g, own: own, cmd: (own ? c1 : c0)});
    dq.push_back('{cyc: d, own: own, rd: m_rd, to: to});
    rq.push_back('{to: to, k: k, data: data});
    while (cyc < g) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = 16'($urandom); cmd1 = 16'($urandom);
    while (cyc < d) @(negedge clk);
  endtask

  // Both requesters held for n back-to-back transactions.
  task automatic run_held(input int n, input logic [15:0] c0, input logic [15:0] c1);
    int g, d, k;
    bit own;
    logic [15:0] data;
    req0 = 1'b1; req1 = 1'b1; cmd0 = c0; cmd1 = c1;
    g = cyc + 1;
    d = g;
    for (int i = 0; i < n; i++) begin
      own    = ~m_last;
      m_last = own;
      k      = $urandom_range(1, TMO - 1);
      data   = 16'($urandom);
      d      = g + k + 1;
      m_rd   = data;
      gq.push_back('{cyc: g, own: own, cmd: (own ? c1 : c0)});
      dq.push_back('{cyc: d, own: own, rd: m_rd, to: 1'b0});
      rq.push_back('{to: 1'b0, k: k, data: data});
      if (i < n - 1) g = d + 1;
    end
    while (cyc < g) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    while (cyc < d) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, m, k, g;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; cmd0 = 16'h0000; cmd1 = 16'h0000;
    repeat (3) @(negedge clk);
    chk({gnt0, gnt1, done0, done1, timeout, wrt, busy} == 7'd0, "reset_flags",
        {25'd0, gnt0, gnt1, done0, done1, timeout, wrt, busy}, 0);
    chk(cmd == 16'h0000, "reset_cmd", cmd, 0);
    chk(rd_data == 16'h0000, "reset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_held(6, 16'h2062, 16'hA600);
    run_txn(1'b1, 1'b0, 16'h8F00, 16'h0000, 1, 1'b0, 12, 16'h006A);
    run_txn(1'b0, 1'b1, 16'h0000, 16'hA900, 2, 1'b0, TMO, 16'h1234);
    run_txn(1'b0, 1'b1, 16'h0000, 16'hAA00, 0, 1'b1, 0, 16'h0000);
    run_txn(1'b1, 1'b0, 16'h1053, 16'h0000, 0, 1'b0, 3, 16'h00C3);

    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(0, 2);
      m = $urandom_range(0, 7);
      k = (m == 2) ? TMO : $urandom_range(1, TMO - 1);
      run_txn(p != 1, p != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 3),
              m < 2, k, 16'($urandom));
    end

    // spi_done while idle must be ignored.
    repeat (2) @(negedge clk);
    idle_pulse_n = idle_pulse_n + 1;
    repeat (4) @(negedge clk);
    chk(rd_data == m_rd, "idle_spi_done_ignored", rd_data, m_rd);

    // Reset in the middle of a WAIT; the aborted transaction never completes.
    req0 = 1'b1; cmd0 = 16'h5A5A;
    g = cyc + 1;
    gq.push_back('{cyc: g, own: 1'b0, cmd: 16'h5A5A});
    rq.push_back('{to: 1'b1, k: 0, data: 16'h0000});
    while (cyc < g) @(negedge clk);
    req0 = 1'b0;
    while (cyc < g + 4) @(negedge clk);
    chk(busy == 1'b1, "busy_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk({gnt0, gnt1, done0, done1, timeout, wrt, busy} == 7'd0, "midreset_flags",
        {25'd0, gnt0, gnt1, done0, done1, timeout, wrt, busy}, 0);
    chk(cmd == 16'h0000, "midreset_cmd", cmd, 0);
    chk(rd_data == 16'h0000, "midreset_rd_data", rd_data, 0);
    m_last = 1'b1;
    m_rd   = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 1'b1, 16'h1111, 16'h2222, 0, 1'b0, 5, 16'h4321);
    run_txn(1'b1, 1'b1, 16'h3333, 16'h4444, 0, 1'b0, 2, 16'h8765);

    repeat (5) @(negedge clk);
    chk(gq.size() == 0, "grants_outstanding", gq.size(), 0);
    chk(dq.size() == 0, "dones_outstanding", dq.size(), 0);
    chk(rq.size() == 0, "responses_outstanding", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
